fir_mc_stream: RTL and testbench
================================

// Module: fir_mc_stream
// PURPOSE
//   Parametrised, multi-channel successor to the single-channel FIR engine.
//   - Time-multiplexed MAC FIR: one MAC per cycle, shared by CH channels.
//   - Each channel has its own circular sample history; all channels share one coefficient bank.
//   - Streaming valid/ready on input and output; round-half-up, saturating output.
//   - Sits between the AXI sample path (producer/consumer) and APB config (taps, coefs, clear).
// PARAMETERS
//   DATA_W    16  sample and output width, signed two's complement
//   COEF_W    16  coefficient width, signed
//   MAX_TAPS  32  coefficient bank depth = per-channel history depth (power of 2, >=2)
//   CH        4   number of independent channels (>=1)
//   FRAC      15  coefficient fractional bits; result = acc >>> FRAC (FRAC >= 1)
//   ACC_W     DATA_W+COEF_W+$clog2(MAX_TAPS)  accumulator width (derived, localparam)
// PORTS
//   a_clk      in   1                    clock
//   a_rst_n    in   1                    async active-low reset
//   cfg_taps   in   $clog2(MAX_TAPS)+1   active tap count; sampled at input accept
//   coef_we    in   1                    coefficient write strobe
//   coef_addr  in   $clog2(MAX_TAPS)     coefficient index k
//   coef_data  in   COEF_W               coefficient value
//   hist_clr   in   1                    zero all histories and write pointers
//   s_valid    in   1                    input sample valid
//   s_ready    out  1                    input ready
//   s_data     in   DATA_W               input sample
//   s_ch       in   $clog2(CH)+1         input channel index (one extra bit so out-of-range is encodable)
//   m_valid    out  1                    output valid
//   m_ready    in   1                    output ready
//   m_data     out  DATA_W               filtered sample
//   m_ch       out  $clog2(CH)+1         channel of m_data
//   m_sat      out  1                    m_data was saturated
//   busy       out  1                    FSM not in IDLE
//   ch_err     out  1                    1-cycle pulse: sample with s_ch>=CH dropped
// BEHAVIOUR
//   Reset (async, all regs): state=IDLE, s_ready=1, m_valid=0, m_data=0, m_ch=0, m_sat=0, busy=0, ch_err=0.
//     Reset also clears all coefs, histories and write pointers, including mid-MAC or mid-OUT.
//   FSM: IDLE -> MAC -> OUT -> IDLE. s_ready = (state==IDLE). busy = (state!=IDLE).
//   IDLE, s_valid=1, s_ch<CH (accept):
//     - latch ch, taps_eff = clamp(cfg_taps, 1, MAX_TAPS)
//     - hist[ch][wp[ch]] <= s_data; wp[ch] <= wp[ch]+1 mod MAX_TAPS
//     - acc <= 0, k <= 0; go to MAC
//   IDLE, s_valid=1, s_ch>=CH: sample consumed and dropped; ch_err=1 next cycle; stay in IDLE.
//   MAC: one cycle per tap.
//     - acc += hist[ch][(wp_at_accept - k) mod MAX_TAPS] * coef[k], sign-extended to ACC_W
//     - tap k=0 is the newest sample
//     - k == taps_eff-1: go to OUT
//   OUT entry: m_data = sat_DATA_W((acc + 2^(FRAC-1)) >>> FRAC) (arithmetic shift).
//     - m_sat=1 iff clamped to +2^(DATA_W-1)-1 or -2^(DATA_W-1); m_ch=ch; m_valid=1
//   Latency: accept at cycle T -> m_valid at T+taps_eff+1.
//   OUT: hold m_data/m_ch/m_sat/m_valid stable until m_ready=1.
//     - on handshake: m_valid=0, go to IDLE; next accept no earlier than the following cycle
//   coef_we: applied in any state except MAC; ignored while in MAC, so coefs stay stable during a computation.
//   hist_clr: applied only in IDLE, ignored otherwise.
//     - in the same IDLE cycle as s_valid, clear wins and s_ready is forced 0 that cycle
//   cfg_taps changes while busy: no effect on the computation in flight.
//   Pointer wrap: wp[ch] rolls MAX_TAPS-1 -> 0; history reads wrap mod MAX_TAPS.
// STRUCTURE
//   fir_pkg: state_e {IDLE,MAC,OUT}; function sat_round(acc) returning {sat,data}; clamp constants.
//   Sub-module fir_round_sat: combinational round+saturate, ACC_W -> DATA_W, with sat flag.
//   History: CH x MAX_TAPS register array (or RAM, 1 write + 1 read per cycle); wp[CH] counters.
// TESTING
//   Impulse, CH=4, taps=4, coef={0x4000,0x2000,0x1000,0x0800}, ch2 gets 0x7FFF then 0s
//     -> ch2 outputs 0x4000,0x2000,0x1000,0x0800,0; m_sat=0; latency 5 cycles.
//   Saturation: taps=2, coefs 0x7FFF, two samples 0x7FFF
//     -> m_data 0x7FFF, m_sat=1; with samples 0x8000 -> 0x8000, m_sat=1.
//   Channel isolation: interleave ch0=100, ch1=-100 with taps=3 coef=0x8000 (-1.0)
//     -> each channel's output depends only on its own history.
//   Backpressure: m_ready=0 for 10 cycles in OUT
//     -> m_data/m_valid stable, s_ready=0; accept resumes after the handshake.
//   Wrap + clear: 40 samples to ch1 with MAX_TAPS=32 -> correct taps across the wrap.
//     - then hist_clr in IDLE -> next output equals s_data*coef[0] only.
//   Edge cases, each checked separately:
//     - s_ch=CH -> ch_err pulse, no m_valid
//     - cfg_taps=0 -> behaves as 1 tap
//     - coef_we during MAC -> ignored
//     - a_rst_n low during MAC -> all outputs at reset values immediately

Source files
------------

// File: rtl/fir_mc_stream_pkg.sv
// Shared types and helpers for the multi-channel streaming FIR.
package fir_mc_stream_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  // Index width that stays at least one bit wide for single-entry arrays.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mc_stream_if.sv
// Sample-in / result-out valid-ready streams of the FIR engine.
interface fir_mc_stream_if #(
  parameter int DATA_W = 16,
  parameter int CH     = 4
);
  localparam int CH_W = $clog2(CH) + 1;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [CH_W-1:0]   s_ch;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CH_W-1:0]   m_ch;
  logic              m_sat;

  modport slave (
    input  s_valid, s_data, s_ch, m_ready,
    output s_ready, m_valid, m_data, m_ch, m_sat
  );

  modport master (
    output s_valid, s_data, s_ch, m_ready,
    input  s_ready, m_valid, m_data, m_ch, m_sat
  );
endinterface

// File: rtl/fir_mc_stream_round_sat.sv
// Round-half-up, arithmetic shift by FRAC, then saturate to DATA_W; purely combinational.
module fir_round_sat #(
  parameter int ACC_W  = 37,
  parameter int DATA_W = 16,
  parameter int FRAC   = 15
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DATA_W-1:0] data,
  output logic                     sat
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shr;

  always_comb begin
    sum  = $signed({acc[ACC_W-1], acc}) + HALF;
    shr  = sum >>> FRAC;
    data = shr[DATA_W-1:0];
    sat  = 1'b0;
    if (shr > MAXV) begin
      data = {1'b0, {(DATA_W-1){1'b1}}};
      sat  = 1'b1;
    end else if (shr < MINV) begin
      data = {1'b1, {(DATA_W-1){1'b0}}};
      sat  = 1'b1;
    end
  end
endmodule

// File: rtl/fir_mc_stream.sv
// Time-multiplexed single-MAC FIR shared by CH channels; one coefficient bank, per-channel history.
// Result appears taps_eff+1 cycles after accept and is held until the consumer takes it.
module fir_mc_stream
  import fir_mc_stream_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int MAX_TAPS = 32,
  parameter int CH       = 4,
  parameter int FRAC     = 15
) (
  input  logic                            a_clk,
  input  logic                            a_rst_n,
  input  logic [$clog2(MAX_TAPS):0]       cfg_taps,
  input  logic                            coef_we,
  input  logic [$clog2(MAX_TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]        coef_data,
  input  logic                            hist_clr,
  fir_mc_stream_if.slave                  bus,
  output logic                            busy,
  output logic                            ch_err
);
  localparam int AW    = $clog2(MAX_TAPS);
  localparam int TW    = AW + 1;
  localparam int CIW   = idx_w(CH);
  localparam int CH_W  = $clog2(CH) + 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = DATA_W + COEF_W + AW;

  state_e state, state_nx;

  logic [CIW-1:0]           ch_q, s_idx;
  logic [TW-1:0]            taps_q, k_q, taps_clamp;
  logic [AW-1:0]            base_q, rd_idx;
  logic signed [ACC_W-1:0]  acc_q, acc_nx;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] hist [CH][MAX_TAPS];
  logic signed [COEF_W-1:0] coef [MAX_TAPS];
  logic [AW-1:0]            wp [CH];
  logic                     ch_ok, take, accept, drop, clr_en, last;
  logic [DATA_W-1:0]        rs_data;
  logic                     rs_sat;

  // A clear request steals the IDLE cycle, so no sample can slip in alongside it.
  assign clr_en      = (state == IDLE) && hist_clr;
  assign bus.s_ready = (state == IDLE) && !hist_clr;
  assign take        = bus.s_valid && bus.s_ready;
  assign ch_ok       = bus.s_ch < CH_W'(CH);
  assign s_idx       = bus.s_ch[CIW-1:0];
  assign accept      = take && ch_ok;
  assign drop        = take && !ch_ok;
  assign last        = (k_q == taps_q - TW'(1));
  assign busy        = (state != IDLE);
  assign bus.m_valid = (state == OUT);

  // Tap k reads k samples back from the slot written at accept.
  assign rd_idx = base_q - k_q[AW-1:0];
  assign prod   = PW'(hist[ch_q][rd_idx]) * PW'(coef[k_q[AW-1:0]]);
  assign acc_nx = acc_q + ACC_W'(prod);

  always_comb begin
    taps_clamp = cfg_taps;
    if (cfg_taps == '0)
      taps_clamp = TW'(1);
    else if (cfg_taps > TW'(MAX_TAPS))
      taps_clamp = TW'(MAX_TAPS);
  end

  fir_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC(FRAC)) u_round_sat (
    .acc  (acc_nx),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)      state_nx = MAC;
      MAC:     if (last)        state_nx = OUT;
      OUT:     if (bus.m_ready) state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      ch_q       <= '0;
      taps_q     <= TW'(1);
      k_q        <= '0;
      base_q     <= '0;
      acc_q      <= '0;
      bus.m_data <= '0;
      bus.m_ch   <= '0;
      bus.m_sat  <= 1'b0;
      ch_err     <= 1'b0;
      for (int t = 0; t < MAX_TAPS; t++) coef[t] <= '0;
      for (int c = 0; c < CH; c++) begin
        wp[c] <= '0;
        for (int t = 0; t < MAX_TAPS; t++) hist[c][t] <= '0;
      end
    end else begin
      ch_err <= drop;
      if (coef_we && state != MAC)
        coef[coef_addr] <= coef_data;
      if (clr_en) begin
        for (int c = 0; c < CH; c++) begin
          wp[c] <= '0;
          for (int t = 0; t < MAX_TAPS; t++) hist[c][t] <= '0;
        end
      end
      if (accept) begin
        ch_q               <= s_idx;
        taps_q             <= taps_clamp;
        base_q             <= wp[s_idx];
        hist[s_idx][wp[s_idx]] <= bus.s_data;
        wp[s_idx]          <= wp[s_idx] + AW'(1);
        acc_q              <= '0;
        k_q                <= '0;
      end
      if (state == MAC) begin
        acc_q <= acc_nx;
        k_q   <= k_q + TW'(1);
        if (last) begin
          bus.m_data <= rs_data;
          bus.m_sat  <= rs_sat;
          bus.m_ch   <= CH_W'(ch_q);
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_mc_stream.sv
// Scoreboard bench for fir_mc_stream: a reference model pushes expected results at accept time.
module tb_fir_mc_stream;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int MAX_TAPS = 32;
  localparam int CH       = 4;
  localparam int FRAC     = 15;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] data;
    logic        sat;
  } exp_t;

  logic        a_clk = 1'b0;
  logic        a_rst_n = 1'b0;
  logic [5:0]  cfg_taps;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        hist_clr;
  logic        busy;
  logic        ch_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  exp_t        sb[$];
  logic signed [15:0] mhist [CH][MAX_TAPS];
  logic signed [15:0] mcoef [MAX_TAPS];
  int          mwp [CH];
  logic [15:0] last_data;
  logic        last_sat;
  logic [15:0] held;
  logic [15:0] imp_exp [5];

  fir_mc_stream_if #(.DATA_W(DATA_W), .CH(CH)) bus ();

  fir_mc_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS), .CH(CH), .FRAC(FRAC)
  ) dut (
    .a_clk     (a_clk),
    .a_rst_n   (a_rst_n),
    .cfg_taps  (cfg_taps),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .hist_clr  (hist_clr),
    .bus       (bus),
    .busy      (busy),
    .ch_err    (ch_err)
  );

  always #5 a_clk = ~a_clk;
  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff_taps(input int taps);
    return (taps == 0) ? 1 : ((taps > MAX_TAPS) ? MAX_TAPS : taps);
  endfunction

  function automatic exp_t model(input int ch, input int taps);
    exp_t   e;
    longint acc, r;
    acc = 0;
    for (int k = 0; k < eff_taps(taps); k++)
      acc += longint'(mhist[ch][(mwp[ch] - 1 - k) & (MAX_TAPS - 1)]) * longint'(mcoef[k]);
    r = (acc + 64'sd16384) >>> 15;
    e.ch = 3'(ch);
    if (r > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (r < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = 16'(r); e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic model_clear_hist();
    for (int c = 0; c < CH; c++) begin
      mwp[c] = 0;
      for (int t = 0; t < MAX_TAPS; t++) mhist[c][t] = '0;
    end
  endtask

  // Output side: every completed handshake is compared against the queue head.
  always @(negedge a_clk) begin
    if (a_rst_n && bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", bus.m_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("m_data", bus.m_data, e.data);
        check("m_ch", bus.m_ch, e.ch);
        check("m_sat", bus.m_sat, e.sat);
        last_data = bus.m_data;
        last_sat  = bus.m_sat;
      end
    end
  end

  task automatic set_coef(input int k, input int v);
    @(posedge a_clk); #1;
    coef_we = 1'b1; coef_addr = 5'(k); coef_data = 16'(v);
    @(posedge a_clk); #1;
    coef_we = 1'b0;
    mcoef[k] = 16'(v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge a_clk); n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic send(input int ch, input int data, input int taps, input bit poke, input bit wait_out);
    int     n;
    longint acc_cyc;
    @(posedge a_clk); #1;
    bus.s_valid = 1'b1; bus.s_data = 16'(data); bus.s_ch = 3'(ch); cfg_taps = 6'(taps);
    n = 0;
    @(negedge a_clk);
    while (!bus.s_ready && n < 100) begin
      @(negedge a_clk); n++;
    end
    if (!bus.s_ready) begin
      check("accept_timeout", bus.s_ready, 1);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge a_clk); #1;
    acc_cyc = cyc;
    bus.s_valid = 1'b0;
    cfg_taps = 6'($urandom_range(0, 63));
    if (ch >= CH) begin
      @(negedge a_clk);
      check("ch_err_pulse", ch_err, 1);
      check("ch_err_busy", busy, 0);
      check("ch_err_no_valid", bus.m_valid, 0);
      @(negedge a_clk);
      check("ch_err_one_cycle", ch_err, 0);
      return;
    end
    mhist[ch][mwp[ch]] = 16'(data);
    mwp[ch] = (mwp[ch] + 1) % MAX_TAPS;
    sb.push_back(model(ch, taps));
    if (poke) begin
      coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'h7FFF;
      @(posedge a_clk); #1;
      coef_we = 1'b0;
    end
    if (!wait_out) return;
    n = 0;
    @(negedge a_clk);
    while (!bus.m_valid && n < 100) begin
      @(negedge a_clk); n++;
    end
    if (!bus.m_valid) check("m_valid_timeout", bus.m_valid, 1);
    else check("latency", cyc - acc_cyc + 1, eff_taps(taps) + 1);
    drain();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_ch = '0; bus.m_ready = 1'b1;
    cfg_taps = 6'd1; coef_we = 1'b0; coef_addr = '0; coef_data = '0; hist_clr = 1'b0;
    for (int t = 0; t < MAX_TAPS; t++) mcoef[t] = '0;
    model_clear_hist();
    imp_exp[0] = 16'h4000; imp_exp[1] = 16'h2000; imp_exp[2] = 16'h1000;
    imp_exp[3] = 16'h0800; imp_exp[4] = 16'h0000;

    #12;
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_ch", bus.m_ch, 0);
    check("rst_m_sat", bus.m_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_ch_err", ch_err, 0);
    @(negedge a_clk); a_rst_n = 1'b1;

    // Impulse on channel 2.
    set_coef(0, 'h4000); set_coef(1, 'h2000); set_coef(2, 'h1000); set_coef(3, 'h0800);
    for (int i = 0; i < 5; i++) begin
      send(2, (i == 0) ? 'h7FFF : 0, 4, 0, 1);
      check("impulse_data", last_data, imp_exp[i]);
      check("impulse_sat", last_sat, 0);
    end

    // Saturation both directions.
    set_coef(0, 'h7FFF); set_coef(1, 'h7FFF);
    send(3, 'h7FFF, 2, 0, 1);
    send(3, 'h7FFF, 2, 0, 1);
    check("sat_pos_data", last_data, 16'h7FFF);
    check("sat_pos_flag", last_sat, 1);
    send(3, 'h8000, 2, 0, 1);
    send(3, 'h8000, 2, 0, 1);
    check("sat_neg_data", last_data, 16'h8000);
    check("sat_neg_flag", last_sat, 1);

    // Interleaved channels with a -1.0 filter.
    set_coef(0, 'h8000); set_coef(1, 'h8000); set_coef(2, 'h8000);
    for (int i = 0; i < 4; i++) begin
      send(0, 100, 3, 0, 1);
      send(1, -100, 3, 0, 1);
    end
    check("isolation_ch1", last_data, 16'd300);

    // Consumer stalls for 10 cycles.
    bus.m_ready = 1'b0;
    send(0, 1234, 3, 0, 0);
    begin
      int n;
      n = 0;
      @(negedge a_clk);
      while (!bus.m_valid && n < 100) begin
        @(negedge a_clk); n++;
      end
      check("bp_m_valid_rise", bus.m_valid, 1);
    end
    held = bus.m_data;
    repeat (10) begin
      @(negedge a_clk);
      check("bp_valid", bus.m_valid, 1);
      check("bp_data", bus.m_data, held);
      check("bp_s_ready", bus.s_ready, 0);
    end
    @(posedge a_clk); #1; bus.m_ready = 1'b1;
    drain();
    send(1, 55, 3, 0, 1);

    // History wrap on channel 1.
    for (int k = 0; k < MAX_TAPS; k++) set_coef(k, (((k * 37) % 200) - 100) * 64);
    for (int i = 0; i < 40; i++)
      send(1, $urandom_range(0, 65535), (i % 4 == 0) ? $urandom_range(1, 32) : 32, 0, 1);

    // Clear collides with a valid sample: clear wins.
    @(posedge a_clk); #1;
    hist_clr = 1'b1; bus.s_valid = 1'b1; bus.s_ch = 3'd1; bus.s_data = 16'd999;
    @(negedge a_clk);
    check("clr_blocks_ready", bus.s_ready, 0);
    @(posedge a_clk); #1;
    hist_clr = 1'b0; bus.s_valid = 1'b0;
    model_clear_hist();
    send(1, 300, 8, 0, 1);

    // Out-of-range channels.
    send(4, 123, 4, 0, 1);
    send(7, 456, 4, 0, 1);

    // Zero taps behaves as one tap.
    send(0, 1000, 0, 0, 1);

    // Coefficient write during MAC is ignored.
    set_coef(0, 'h2000);
    send(2, 4000, 8, 1, 1);
    send(2, 4000, 1, 0, 1);

    // Reset in the middle of a computation.
    send(0, 500, 16, 0, 0);
    repeat (3) @(posedge a_clk);
    #3 a_rst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    check("mid_rst_m_ch", bus.m_ch, 0);
    check("mid_rst_m_sat", bus.m_sat, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ch_err", ch_err, 0);
    sb.delete();
    model_clear_hist();
    for (int t = 0; t < MAX_TAPS; t++) mcoef[t] = '0;
    @(posedge a_clk); #3 a_rst_n = 1'b1;
    set_coef(0, 'h4000);
    send(3, 'h1000, 1, 0, 1);
    check("post_rst_data", last_data, 16'h0800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
